// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-step shift sequencer and the single-step shifter stage.
// Holds the FSM state encoding, shifter select codes and default widths.
package shift_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AMT_W = 4;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a requester and the shift sequencer.
// Requester drives start/dir/amount/operand; sequencer returns ready/done/result.
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic             dir;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] operand;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, dir, amount, operand,
        input  ready, done, result
    );

    modport slave (
        input  start, dir, amount, operand,
        output ready, done, result
    );
endinterface

// File: rtl/shift_stage.sv
// Single-step arithmetic shifter stage: load, hold, or one-bit shift of its data input.
// Latency 1 cycle (registered output); no backpressure, acts every cycle on s.
import shift_pkg::*;

module shift_stage #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Right replicates the MSB, left replicates the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            case (s)
                SEL_RIGHT: q <= {d[WIDTH-1], d[WIDTH-1:1]};
                SEL_LEFT:  q <= {d[WIDTH-2:0], d[0]};
                SEL_LOAD:  q <= d;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Drives a single-step shifter through load + N shift steps, then returns the value with a done pulse.
// Latency N+3 cycles from accept; ready only in IDLE, start while busy is dropped.
import shift_pkg::*;

module shift_sequencer #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic                clk,
    input  logic                rst,
    shift_sequencer_if.slave    bus,
    output logic [1:0]          sh_sel,
    output logic [WIDTH-1:0]    sh_data,
    input  logic [WIDTH-1:0]    sh_result
);

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] amt_q;
    logic             dir_q;
    logic [WIDTH-1:0] op_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             ready_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            amt_q    <= '0;
            dir_q    <= 1'b0;
            op_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.operand;
                        dir_q <= bus.dir;
                        amt_q <= bus.amount;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= amt_q;
                    state <= (amt_q == '0) ? CAPTURE : SHIFT;
                end
                SHIFT: begin
                    // Zero amounts never reach here, so cnt cannot underflow.
                    cnt <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) state <= CAPTURE;
                end
                CAPTURE: begin
                    result_q <= sh_result;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decoded from state only; sh_result feedback is itself a register.
    always_comb begin
        ready_c = 1'b0;
        sh_sel  = SEL_HOLD;
        sh_data = '0;
        case (state)
            IDLE: ready_c = 1'b1;
            LOAD: begin
                sh_sel  = SEL_LOAD;
                sh_data = op_q;
            end
            SHIFT: begin
                sh_sel  = dir_q ? SEL_LEFT : SEL_RIGHT;
                sh_data = sh_result;
            end
            default: ;
        endcase
    end

    assign bus.ready  = ready_c;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer wired to shift_stage; directed vectors with hand-computed results.
import shift_pkg::*;

module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic [1:0]  sh_sel;
    logic [15:0] sh_data;
    logic [15:0] sh_result;

    shift_sequencer_if #(.WIDTH(16), .AMT_W(4)) bus ();

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sh_sel    (sh_sel),
        .sh_data   (sh_data),
        .sh_result (sh_result)
    );

    shift_stage #(.WIDTH(16)) stage (
        .clk (clk),
        .rst (rst),
        .s   (sh_sel),
        .d   (sh_data),
        .q   (sh_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic        d;
        logic [3:0]  amt;
        logic [15:0] res;
        int          lat;
        bit          no_step;
    } vec_t;

    vec_t vecs[8];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One full operation; ghost_cyc>0 pulses a competing start in that busy cycle.
    task automatic run_op(input logic [15:0] op, input logic d, input logic [3:0] amt,
                          input logic [15:0] exp_res, input int exp_lat,
                          input bit no_step, input int ghost_cyc);
        int  lat;
        bit  stepped;
        bit  busy_ready;
        @(negedge clk);
        check("ready_before_start", {31'b0, bus.ready}, 32'd1);
        bus.start   = 1'b1;
        bus.operand = op;
        bus.dir     = d;
        bus.amount  = amt;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.operand = 16'hA5A5;
        bus.dir     = ~d;
        bus.amount  = 4'h9;
        lat = -1;
        stepped = 1'b0;
        busy_ready = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (k == ghost_cyc) begin
                bus.start   = 1'b1;
                bus.operand = 16'hFFFF;
                bus.dir     = 1'b1;
                bus.amount  = 4'h1;
            end else begin
                bus.start = 1'b0;
            end
            if (sh_sel == SEL_RIGHT || sh_sel == SEL_LEFT) stepped = 1'b1;
            if (bus.ready) busy_ready = 1'b1;
            if (bus.done) lat = k;
        end
        bus.start = 1'b0;
        check("latency", lat, exp_lat);
        check("result", bus.result, {16'b0, exp_res});
        check("ready_low_while_busy", {31'b0, busy_ready}, 32'd0);
        if (no_step) check("no_shift_select", {31'b0, stepped}, 32'd0);
        @(negedge clk);
        check("ready_after_done", {31'b0, bus.ready}, 32'd1);
        check("done_one_cycle", {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        bit extra_done;

        vecs[0] = '{op: 16'h8004, d: 1'b0, amt: 4'd2,  res: 16'hE001, lat: 5,  no_step: 1'b0};
        vecs[1] = '{op: 16'h0003, d: 1'b1, amt: 4'd3,  res: 16'h001F, lat: 6,  no_step: 1'b0};
        vecs[2] = '{op: 16'h1234, d: 1'b0, amt: 4'd0,  res: 16'h1234, lat: 3,  no_step: 1'b1};
        vecs[3] = '{op: 16'h8000, d: 1'b0, amt: 4'd15, res: 16'hFFFF, lat: 18, no_step: 1'b0};
        vecs[4] = '{op: 16'h8001, d: 1'b1, amt: 4'd1,  res: 16'h0003, lat: 4,  no_step: 1'b0};
        vecs[5] = '{op: 16'h7FFF, d: 1'b0, amt: 4'd4,  res: 16'h07FF, lat: 7,  no_step: 1'b0};
        vecs[6] = '{op: 16'h0002, d: 1'b1, amt: 4'd4,  res: 16'h0020, lat: 7,  no_step: 1'b0};
        vecs[7] = '{op: 16'h0001, d: 1'b1, amt: 4'd15, res: 16'hFFFF, lat: 18, no_step: 1'b0};

        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.dir     = 1'b0;
        bus.amount  = '0;
        bus.operand = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'd1);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_sh_sel", sh_sel, SEL_HOLD);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, bus.ready}, 32'd1);
        check("post_rst_done", {31'b0, bus.done}, 32'd0);
        check("post_rst_result", bus.result, 32'h0);
        check("post_rst_sh_sel", sh_sel, SEL_HOLD);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].d, vecs[i].amt, vecs[i].res, vecs[i].lat,
                   vecs[i].no_step, 0);
        end

        // Competing start in a SHIFT cycle must neither alter nor queue work.
        run_op(16'h00F0, 1'b0, 4'd4, 16'h000F, 7, 1'b0, 3);
        extra_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) extra_done = 1'b1;
        end
        check("ghost_not_queued", {31'b0, extra_done}, 32'd0);

        // Reset in the middle of SHIFT.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = 16'h8000;
        bus.dir     = 1'b0;
        bus.amount  = 4'd8;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("midshift_sel", sh_sel, SEL_RIGHT);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'b0, bus.ready}, 32'd1);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_result", bus.result, 32'h0);
        check("midrst_sh_sel", sh_sel, SEL_HOLD);
        check("midrst_sh_data", sh_data, 32'h0);
        check("midrst_sh_result", sh_result, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        run_op(16'h8004, 1'b0, 4'd2, 16'hE001, 5, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
